// File: rtl/ipv4_checksum_insert.sv
// Transmit-side IPv4 header checksum insertion for the 256-bit AXI4-Stream datapath.
// Optional build macro TTL_DEC_EN: decrement TTL of eligible packets before checksumming.
module ipv4_checksum_insert #(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                                 AXI_ACLK,
  input  logic                                 AXI_RESETN,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      S_AXIS_TUSER,
  input  logic                                 S_AXIS_TVALID,
  input  logic                                 S_AXIS_TLAST,
  output logic                                 S_AXIS_TREADY,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]       M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      M_AXIS_TUSER,
  output logic                                 M_AXIS_TVALID,
  output logic                                 M_AXIS_TLAST,
  input  logic                                 M_AXIS_TREADY,
  output logic [31:0]                          csum_insert_count,
  output logic [31:0]                          csum_bypass_count
);

  localparam int unsigned DW   = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned SW   = C_S_AXIS_DATA_WIDTH / 8;
  localparam int unsigned UW   = C_S_AXIS_TUSER_WIDTH;
  localparam int unsigned ACCW = 20;
  localparam int unsigned CNTW = 32;

  typedef enum logic [2:0] {
    S_HEAD,
    S_WAIT2,
    S_SUM,
    S_OUT1,
    S_OUT2,
    S_PASS
  } state_e;

  state_e state_q, state_d;

  logic [DW-1:0]   data1_q, data1_d, data2_q, data2_d;
  logic [SW-1:0]   strb1_q, strb1_d, strb2_q, strb2_d;
  logic [UW-1:0]   user1_q, user1_d, user2_q, user2_d;
  logic            last1_q, last1_d, last2_q, last2_d;
  logic            elig_q, elig_d;
  logic [ACCW-1:0] psum_q, psum_d;
  logic [15:0]     csum_q, csum_d;
  logic [CNTW-1:0] ins_cnt_q, ins_cnt_d, byp_cnt_q, byp_cnt_d;

  logic            elig_c;
  logic [DW-1:0]   beat1_in_c;
  logic [DW-1:0]   out1_data_c;
  logic [ACCW-1:0] psum_c, sum_full_c, fold1_c;
  logic [15:0]     fold2_c;
  logic            s_ready_c;

  // Eligibility needs a second beat to carry the rest of the destination address
  assign elig_c = (S_AXIS_TDATA[159:144] == 16'h0800) &&
                  (S_AXIS_TDATA[143:136] == 8'h45) && !S_AXIS_TLAST;

  always_comb begin
    beat1_in_c = S_AXIS_TDATA;
`ifdef TTL_DEC_EN
    if (elig_c && (S_AXIS_TDATA[79:72] != 8'h00)) begin
      beat1_in_c[79:72] = S_AXIS_TDATA[79:72] - 8'h01;
    end
`endif
  end

  // Eight beat-1 header words, checksum field excluded
  assign psum_c = ACCW'(data1_q[143:128]) + ACCW'(data1_q[127:112]) +
                  ACCW'(data1_q[111:96])  + ACCW'(data1_q[95:80])   +
                  ACCW'(data1_q[79:64])   + ACCW'(data1_q[47:32])   +
                  ACCW'(data1_q[31:16])   + ACCW'(data1_q[15:0]);

  assign sum_full_c = psum_q + ACCW'(data2_q[255:240]);
  assign fold1_c    = ACCW'(sum_full_c[15:0]) + ACCW'(sum_full_c[19:16]);
  assign fold2_c    = fold1_c[15:0] + 16'(fold1_c[19:16]);

  always_comb begin
    out1_data_c = data1_q;
    if (elig_q) begin
      out1_data_c[63:48] = csum_q;
    end
  end

  assign S_AXIS_TREADY     = s_ready_c & AXI_RESETN;
  assign csum_insert_count = ins_cnt_q;
  assign csum_bypass_count = byp_cnt_q;

  // Next-state, hold-register and stream output logic
  always_comb begin
    state_d   = state_q;
    data1_d   = data1_q;
    strb1_d   = strb1_q;
    user1_d   = user1_q;
    last1_d   = last1_q;
    data2_d   = data2_q;
    strb2_d   = strb2_q;
    user2_d   = user2_q;
    last2_d   = last2_q;
    elig_d    = elig_q;
    psum_d    = psum_q;
    csum_d    = csum_q;
    ins_cnt_d = ins_cnt_q;
    byp_cnt_d = byp_cnt_q;

    s_ready_c     = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TSTRB  = '0;
    M_AXIS_TUSER  = '0;
    M_AXIS_TLAST  = 1'b0;

    unique case (state_q)
      S_HEAD: begin
        s_ready_c = 1'b1;
        if (S_AXIS_TVALID) begin
          data1_d = beat1_in_c;
          strb1_d = S_AXIS_TSTRB;
          user1_d = S_AXIS_TUSER;
          last1_d = S_AXIS_TLAST;
          elig_d  = elig_c;
          state_d = S_AXIS_TLAST ? S_OUT1 : S_WAIT2;
        end
      end

      S_WAIT2: begin
        s_ready_c = 1'b1;
        psum_d    = psum_c;
        if (S_AXIS_TVALID) begin
          data2_d = S_AXIS_TDATA;
          strb2_d = S_AXIS_TSTRB;
          user2_d = S_AXIS_TUSER;
          last2_d = S_AXIS_TLAST;
          state_d = S_SUM;
        end
      end

      S_SUM: begin
        csum_d  = ~fold2_c;
        state_d = S_OUT1;
      end

      S_OUT1: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = out1_data_c;
        M_AXIS_TSTRB  = strb1_q;
        M_AXIS_TUSER  = user1_q;
        M_AXIS_TLAST  = last1_q;
        if (M_AXIS_TREADY) begin
          if (elig_q) begin
            ins_cnt_d = ins_cnt_q + CNTW'(1);
          end else begin
            byp_cnt_d = byp_cnt_q + CNTW'(1);
          end
          state_d = last1_q ? S_HEAD : S_OUT2;
        end
      end

      S_OUT2: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = data2_q;
        M_AXIS_TSTRB  = strb2_q;
        M_AXIS_TUSER  = user2_q;
        M_AXIS_TLAST  = last2_q;
        if (M_AXIS_TREADY) begin
          state_d = last2_q ? S_HEAD : S_PASS;
        end
      end

      S_PASS: begin
        s_ready_c     = M_AXIS_TREADY;
        M_AXIS_TVALID = S_AXIS_TVALID;
        M_AXIS_TDATA  = S_AXIS_TDATA;
        M_AXIS_TSTRB  = S_AXIS_TSTRB;
        M_AXIS_TUSER  = S_AXIS_TUSER;
        M_AXIS_TLAST  = S_AXIS_TLAST;
        if (S_AXIS_TVALID && M_AXIS_TREADY && S_AXIS_TLAST) begin
          state_d = S_HEAD;
        end
      end

      default: begin
        state_d = S_HEAD;
      end
    endcase
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      state_q   <= S_HEAD;
      data1_q   <= '0;
      strb1_q   <= '0;
      user1_q   <= '0;
      last1_q   <= 1'b0;
      data2_q   <= '0;
      strb2_q   <= '0;
      user2_q   <= '0;
      last2_q   <= 1'b0;
      elig_q    <= 1'b0;
      psum_q    <= '0;
      csum_q    <= '0;
      ins_cnt_q <= '0;
      byp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      data1_q   <= data1_d;
      strb1_q   <= strb1_d;
      user1_q   <= user1_d;
      last1_q   <= last1_d;
      data2_q   <= data2_d;
      strb2_q   <= strb2_d;
      user2_q   <= user2_d;
      last2_q   <= last2_d;
      elig_q    <= elig_d;
      psum_q    <= psum_d;
      csum_q    <= csum_d;
      ins_cnt_q <= ins_cnt_d;
      byp_cnt_q <= byp_cnt_d;
    end
  end

endmodule
